// File: rtl/dma_ctl.sv
// dma_ctl: cycle-stealing block-copy DMA for the 65C02 bus.
// Steals bursts of RD/WR cycles at instruction boundaries and multiplexes memory between the core and the copier.
module dma_ctl #(
    parameter int BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sync,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    output logic        rdy,
    output logic [15:0] mem_ab,
    output logic [7:0]  mem_do,
    output logic        mem_we,
    input  logic [7:0]  mem_di,
    input  logic [2:0]  reg_sel,
    input  logic        reg_we,
    input  logic [7:0]  reg_di,
    output logic [7:0]  reg_do,
    output logic        irq
);
    typedef enum logic [2:0] {IDLE, ARM, RD, WR, RESUME} state_t;
    state_t      state;
    logic [15:0] src;
    logic [15:0] dst;
    logic [7:0]  len;
    logic [8:0]  bcnt;
    logic        done;
    logic        ie;
    logic        abort_pend;
    logic        fin;
    logic        busy;
    logic        core_bus;
    logic        wr_en;
    logic        ctrl_wr;
    logic        last;
    logic        burst_end;

    assign busy      = state != IDLE;
    assign core_bus  = state == IDLE || state == ARM;
    assign wr_en     = reg_we && rdy;
    assign ctrl_wr   = wr_en && reg_sel == 3'd5;
    assign last      = len == 8'd1 || abort_pend;
    assign burst_end = bcnt + 9'd1 == 9'(BURST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rdy        <= 1'b1;
            src        <= 16'd0;
            dst        <= 16'd0;
            len        <= 8'd0;
            bcnt       <= 9'd0;
            done       <= 1'b0;
            ie         <= 1'b0;
            abort_pend <= 1'b0;
            fin        <= 1'b0;
        end else begin
            if (wr_en && !busy) begin
                case (reg_sel)
                    3'd0: src[7:0]  <= reg_di;
                    3'd1: src[15:8] <= reg_di;
                    3'd2: dst[7:0]  <= reg_di;
                    3'd3: dst[15:8] <= reg_di;
                    3'd4: len       <= reg_di;
                    default: ;
                endcase
            end
            if (ctrl_wr) begin
                ie <= reg_di[7];
                if (reg_di[6])
                    done <= 1'b0;
                // An abort with nothing running or starting has nothing to stop.
                if (reg_di[1] && (busy || reg_di[0]))
                    abort_pend <= 1'b1;
            end
            case (state)
                IDLE: if (ctrl_wr && reg_di[0]) begin
                    state <= ARM;
                    done  <= 1'b0;
                end
                ARM: if (abort_pend) begin
                    state      <= IDLE;
                    done       <= 1'b1;
                    abort_pend <= 1'b0;
                end else if (sync && rdy) begin
                    state <= RD;
                    rdy   <= 1'b0;
                    bcnt  <= 9'd0;
                end
                RD: state <= WR;
                WR: begin
                    src   <= src + 16'd1;
                    dst   <= dst + 16'd1;
                    len   <= len - 8'd1;
                    bcnt  <= bcnt + 9'd1;
                    fin   <= last;
                    state <= (last || burst_end) ? RESUME : RD;
                end
                RESUME: begin
                    state <= fin ? IDLE : ARM;
                    rdy   <= 1'b1;
                    if (fin) begin
                        done       <= 1'b1;
                        abort_pend <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RESUME re-presents the core's held address so mem_di is valid when rdy returns.
    assign mem_ab = state == RD ? src : state == WR ? dst : cpu_ab;
    assign mem_do = state == WR ? mem_di : cpu_do;
    assign mem_we = state == WR || (core_bus && cpu_we);
    assign reg_do = reg_sel == 3'd0 ? src[7:0]  :
                    reg_sel == 3'd1 ? src[15:8] :
                    reg_sel == 3'd2 ? dst[7:0]  :
                    reg_sel == 3'd3 ? dst[15:8] :
                    reg_sel == 3'd4 ? len       :
                    reg_sel == 3'd5 ? {ie, done, 5'd0, busy} : 8'd0;
    assign irq    = done && ie;
endmodule

// File: tb/tb_dma_ctl.sv
// tb_dma_ctl: scoreboard bench for dma_ctl with a synchronous memory model.
// Stimulus queues expected values; one monitor compares probes and steal lengths at the falling edge.
module tb_dma_ctl;
    localparam int K_REG = 0, K_MEM = 1, K_RDY = 2, K_IRQ = 3, K_WE = 4, K_AB = 5, K_SQ = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sync = 1'b0;
    logic [15:0] cpu_ab = 16'h1234;
    logic [7:0]  cpu_do = 8'h00;
    logic        cpu_we = 1'b1;
    logic        rdy;
    logic [15:0] mem_ab;
    logic [7:0]  mem_do;
    logic        mem_we;
    logic [7:0]  mem_di;
    logic [2:0]  reg_sel = 3'd0;
    logic        reg_we = 1'b0;
    logic [7:0]  reg_di = 8'd0;
    logic [7:0]  reg_do;
    logic        irq;

    dma_ctl #(.BURST(4)) dut (
        .clk(clk), .reset(reset), .sync(sync), .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
        .rdy(rdy), .mem_ab(mem_ab), .mem_do(mem_do), .mem_we(mem_we), .mem_di(mem_di),
        .reg_sel(reg_sel), .reg_we(reg_we), .reg_di(reg_di), .reg_do(reg_do), .irq(irq)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    bit         wrt [0:65535];

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5C;
    endfunction

    function automatic logic [7:0] rd_mem(input logic [15:0] a);
        return wrt[a] ? mem[a] : pat(a);
    endfunction

    always @(posedge clk) begin
        mem_di <= rd_mem(mem_ab);
        if (mem_we) begin
            mem[mem_ab] <= mem_do;
            wrt[mem_ab] <= 1'b1;
        end
    end

    typedef struct {
        string name;
        int    kind;
        int    addr;
        int    exp;
    } item_t;

    item_t exp_q[$];
    int    steal_q[$];
    logic  probe = 1'b0;
    int    compared = 0;
    int    mism = 0;
    int    dead = 0;

    function automatic int sample(input item_t it);
        case (it.kind)
            K_REG:   return int'(reg_do);
            K_MEM:   return int'(rd_mem(it.addr[15:0]));
            K_RDY:   return int'(rdy);
            K_IRQ:   return int'(irq);
            K_WE:    return int'(mem_we);
            K_AB:    return int'(mem_ab);
            default: return steal_q.size();
        endcase
    endfunction

    initial forever begin
        item_t it;
        int    act;
        int    e;
        @(negedge clk);
        if (probe) begin
            while (exp_q.size() > 0) begin
                it  = exp_q.pop_front();
                act = sample(it);
                compared++;
                if (act != it.exp) begin
                    mism++;
                    $display("FAIL %s: got %0h expected %0h", it.name, act, it.exp);
                end
            end
        end
        if (!reset)
            dead = 0;
        else if (!rdy)
            dead++;
        else if (dead > 0) begin
            e = steal_q.size() > 0 ? steal_q.pop_front() : 0;
            compared++;
            if (dead != e) begin
                mism++;
                $display("FAIL steal_dead_cycles: got %0d expected %0d", dead, e);
            end
            dead = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int addr, input int exp, input string name);
        item_t it;
        if (kind == K_REG)
            reg_sel = addr[2:0];
        it.name = name;
        it.kind = kind;
        it.addr = addr;
        it.exp  = exp;
        exp_q.push_back(it);
    endtask

    task automatic fire();
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    task automatic chk(input int kind, input int addr, input int exp, input string name);
        push(kind, addr, exp, name);
        fire();
    endtask

    task automatic wr(input logic [2:0] sel, input logic [7:0] val);
        reg_sel = sel;
        reg_di  = val;
        reg_we  = 1'b1;
        tick();
        reg_we  = 1'b0;
    endtask

    task automatic prog(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n);
        wr(3'd0, s[7:0]);
        wr(3'd1, s[15:8]);
        wr(3'd2, d[7:0]);
        wr(3'd3, d[15:8]);
        wr(3'd4, n);
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        tick();
        sync = 1'b0;
    endtask

    task automatic wait_rdy();
        for (int i = 0; i < 100 && !rdy; i++)
            tick();
        if (!rdy)
            chk(K_RDY, 0, 1, "steal_timeout");
    endtask

    initial begin
        tick();
        tick();
        // reset state
        push(K_RDY, 0, 1, "reset_rdy");
        push(K_IRQ, 0, 0, "reset_irq");
        push(K_AB, 0, 'h1234, "reset_mem_ab");
        push(K_WE, 0, 1, "reset_mem_we");
        fire();
        reset = 1'b1;
        cpu_we = 1'b0;
        for (int r = 0; r < 8; r++)
            chk(K_REG, r, 0, $sformatf("reset_reg%0d", r));

        // three-byte copy in one steal
        prog(16'h1000, 16'h2000, 8'd3);
        wr(3'd5, 8'h01);
        chk(K_REG, 5, 'h01, "a_busy_arm");
        chk(K_RDY, 0, 1, "a_no_steal_without_sync");
        steal_q.push_back(7);
        pulse_sync();
        wait_rdy();
        for (int i = 0; i < 3; i++)
            chk(K_MEM, 'h2000 + i, pat(16'h1000 + 16'(i)), $sformatf("a_copy%0d", i));
        chk(K_MEM, 'h2003, pat(16'h2003), "a_no_overrun");
        chk(K_REG, 5, 'h40, "a_done");
        chk(K_REG, 4, 0, "a_len");
        chk(K_REG, 0, 'h03, "a_srcl");
        chk(K_REG, 1, 'h10, "a_srch");
        chk(K_IRQ, 0, 0, "a_irq_masked");

        // ten bytes split into bursts of 4, 4 and 2
        prog(16'h1100, 16'h2100, 8'd10);
        wr(3'd5, 8'h01);
        steal_q.push_back(9);
        pulse_sync();
        wait_rdy();
        chk(K_REG, 4, 6, "b_len_live1");
        chk(K_RDY, 0, 1, "b_core_runs");
        chk(K_REG, 5, 'h01, "b_busy_between");
        steal_q.push_back(9);
        pulse_sync();
        wait_rdy();
        chk(K_REG, 4, 2, "b_len_live2");
        steal_q.push_back(5);
        pulse_sync();
        wait_rdy();
        chk(K_REG, 5, 'h40, "b_done");
        chk(K_MEM, 'h2100, pat(16'h1100), "b_copy0");
        chk(K_MEM, 'h2104, pat(16'h1104), "b_copy4");
        chk(K_MEM, 'h2109, pat(16'h1109), "b_copy9");
        chk(K_MEM, 'h210A, pat(16'h210A), "b_no_overrun");

        // source wraps past FFFF
        prog(16'hFFFE, 16'h4000, 8'd4);
        wr(3'd5, 8'h01);
        steal_q.push_back(9);
        pulse_sync();
        wait_rdy();
        chk(K_MEM, 'h4000, pat(16'hFFFE), "c_src_fffe");
        chk(K_MEM, 'h4002, pat(16'h0000), "c_src_0000");
        chk(K_MEM, 'h4003, pat(16'h0001), "c_src_0001");
        chk(K_REG, 0, 'h02, "c_srcl");
        chk(K_REG, 1, 'h00, "c_srch");

        // destination wraps past FFFF
        prog(16'h5000, 16'hFFFE, 8'd4);
        wr(3'd5, 8'h01);
        steal_q.push_back(9);
        pulse_sync();
        wait_rdy();
        chk(K_MEM, 'hFFFF, pat(16'h5001), "c_dst_ffff");
        chk(K_MEM, 'h0000, pat(16'h5002), "c_dst_0000");
        chk(K_MEM, 'h0001, pat(16'h5003), "c_dst_0001");
        chk(K_REG, 2, 'h02, "c_dstl");
        chk(K_REG, 3, 'h00, "c_dsth");

        // abort lands as a steal begins; core write is held through the steal
        prog(16'h1200, 16'h2200, 8'd8);
        wr(3'd5, 8'h81);
        steal_q.push_back(9);
        pulse_sync();
        wait_rdy();
        steal_q.push_back(3);
        reg_sel = 3'd5;
        reg_di  = 8'h82;
        reg_we  = 1'b1;
        sync    = 1'b1;
        tick();
        reg_we  = 1'b0;
        sync    = 1'b0;
        cpu_ab  = 16'h3000;
        cpu_do  = 8'hA5;
        cpu_we  = 1'b1;
        tick();
        tick();
        push(K_AB, 0, 'h3000, "d_resume_ab");
        push(K_WE, 0, 0, "d_resume_we");
        push(K_RDY, 0, 0, "d_resume_rdy");
        push(K_IRQ, 0, 0, "d_resume_irq");
        fire();
        push(K_AB, 0, 'h3000, "d_pending_ab");
        push(K_WE, 0, 1, "d_pending_we");
        push(K_RDY, 0, 1, "d_pending_rdy");
        push(K_IRQ, 0, 1, "d_irq");
        fire();
        cpu_we = 1'b0;
        chk(K_REG, 4, 3, "d_len_remaining");
        chk(K_REG, 5, 'hC0, "d_ctrl");
        chk(K_MEM, 'h2204, pat(16'h1204), "d_last_byte");
        chk(K_MEM, 'h2205, pat(16'h2205), "d_stopped");
        chk(K_MEM, 'h3000, 'hA5, "d_core_write");

        // abort while armed: no steal, done set
        wr(3'd4, 8'd5);
        wr(3'd5, 8'h81);
        wr(3'd5, 8'h82);
        tick();
        chk(K_REG, 5, 'hC0, "e_abort_arm");
        chk(K_REG, 4, 5, "e_len_kept");
        chk(K_IRQ, 0, 1, "e_irq");
        wr(3'd5, 8'h40);
        chk(K_REG, 5, 'h00, "e_cleared");
        chk(K_IRQ, 0, 0, "e_irq_clear");

        // async reset in WR
        prog(16'h1300, 16'h2300, 8'd4);
        wr(3'd5, 8'h01);
        pulse_sync();
        tick();
        cpu_ab = 16'h3100;
        cpu_do = 8'h5A;
        cpu_we = 1'b1;
        #1 reset = 1'b0;
        push(K_RDY, 0, 1, "f_rdy");
        push(K_WE, 0, 1, "f_mem_we");
        push(K_AB, 0, 'h3100, "f_mem_ab");
        fire();
        reset  = 1'b1;
        cpu_we = 1'b0;
        for (int r = 0; r < 6; r++)
            chk(K_REG, r, 0, $sformatf("f_reg%0d", r));

        chk(K_SQ, 0, 0, "steals_outstanding");
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
